// File: rtl/fpadd_pkg.sv
// Shared types and constants for the FP-adder issue stage.
package fpadd_pkg;

  localparam int unsigned DATA_W      = 32;
  localparam int unsigned TAG_W       = 4;
  localparam int unsigned TIMEOUT_DEF = 63;

  // Issue-sequencer states.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_BLANK = 2'd2,
    S_WAIT  = 2'd3
  } state_t;

  // One buffered operand pair with its tag.
  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [TAG_W-1:0]  tag;
  } pair_t;

  localparam int unsigned PAIR_W = $bits(pair_t);

endpackage

// File: rtl/fpadd_issue_fifo.sv
// Synchronous FIFO for operand pairs: registered pointers and occupancy count.
module fpadd_issue_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 68
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             wr_data,
  input  logic                     pop,
  output logic [W-1:0]             rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Requests are qualified here so callers may present them unconditionally.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointer and occupancy tracking; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + CW'(1);
      end else if (do_pop && !do_push) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/fpadd_issue.sv
// Issue stage for a multi-cycle FP adder: buffers operand pairs, sequences one
// add at a time with a stale-done blanking cycle and a timeout, and holds the
// result until the downstream consumer takes it.
module fpadd_issue
  import fpadd_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              add_start,
  output logic [DATA_W-1:0] add_a,
  output logic [DATA_W-1:0] add_b,
  input  logic              add_done,
  input  logic [DATA_W-1:0] add_sum,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_sum,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_timeout,
  output logic              busy
);

  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam int unsigned FCW   = $clog2(FIFO_DEPTH) + 1;

  state_t             state;
  state_t             state_n;
  logic [CNT_W-1:0]   wait_cnt;
  logic [TAG_W-1:0]   tag_q;

  pair_t              fifo_wr;
  pair_t              fifo_head;
  logic               fifo_full;
  logic               fifo_empty;
  logic [FCW-1:0]     fifo_count;
  logic               fifo_pop;

  logic               cnt_clr;
  logic               cnt_inc;
  logic               cap_done;
  logic               cap_to;
  logic               last_wait;

  assign fifo_wr = '{a: in_a, b: in_b, tag: in_tag};

  fpadd_issue_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (PAIR_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (in_valid),
    .wr_data (fifo_wr),
    .pop     (fifo_pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Held low during reset so nothing is accepted on the reset edge.
  assign in_ready  = !fifo_full && !reset;
  assign add_start = (state == S_ISSUE);
  assign busy      = (state != S_IDLE) || (fifo_count != '0) || out_valid;

  // The counter holds the number of WAIT cycles already spent without done, so
  // the final permitted WAIT cycle is the one where it reads TIMEOUT-1.
  assign last_wait = (wait_cnt == CNT_W'(TIMEOUT - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state and datapath control decode.
  always_comb begin
    state_n  = state;
    fifo_pop = 1'b0;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    cap_done = 1'b0;
    cap_to   = 1'b0;
    unique case (state)
      S_IDLE: begin
        // Issue only when the result slot is free or frees this cycle.
        if (!fifo_empty && (!out_valid || out_ready)) begin
          fifo_pop = 1'b1;
          state_n  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_n = S_BLANK;
      end
      S_BLANK: begin
        // done may still be high from the previous add; it is ignored here.
        cnt_clr = 1'b1;
        state_n = S_WAIT;
      end
      S_WAIT: begin
        if (add_done) begin
          cap_done = 1'b1;
          state_n  = S_IDLE;
        end else if (last_wait) begin
          cap_to  = 1'b1;
          state_n = S_IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // Operand latch, wait counter and result register.
  always_ff @(posedge clk) begin
    if (reset) begin
      add_a       <= '0;
      add_b       <= '0;
      tag_q       <= '0;
      wait_cnt    <= '0;
      out_valid   <= 1'b0;
      out_sum     <= '0;
      out_tag     <= '0;
      out_timeout <= 1'b0;
    end else begin
      if (fifo_pop) begin
        add_a <= fifo_head.a;
        add_b <= fifo_head.b;
        tag_q <= fifo_head.tag;
      end

      if (cnt_clr) begin
        wait_cnt <= '0;
      end else if (cnt_inc) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end

      // A capture takes priority over a drain in the same cycle.
      if (cap_done) begin
        out_valid   <= 1'b1;
        out_sum     <= add_sum;
        out_tag     <= tag_q;
        out_timeout <= 1'b0;
      end else if (cap_to) begin
        out_valid   <= 1'b1;
        out_sum     <= '0;
        out_tag     <= tag_q;
        out_timeout <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fpadd_issue.sv
// Directed scoreboard bench for fpadd_issue with a behavioural adder model.
module tb_fpadd_issue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TO    = 15;

  localparam int M_REAL  = 0;
  localparam int M_NEVER = 1;
  localparam int M_STALE = 2;

  typedef struct packed {
    logic [31:0] sum;
    logic [3:0]  tag;
    logic        to;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic [3:0]  in_tag = '0;
  logic        add_start;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic        add_done;
  logic [31:0] add_sum;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_sum;
  logic [3:0]  out_tag;
  logic        out_timeout;
  logic        busy;

  int n_assert = 0;
  int n_fail   = 0;

  exp_t sb[$];
  exp_t pend;
  int   cyc = 0;
  int   rise_cyc = 0;
  int   start_cyc = 0;
  int   last_out_cyc = 0;
  int   out_count = 0;
  int   n_accepted = 0;
  logic prev_done = 1'b0;
  logic chk_lat = 1'b0;

  // Adder model state.
  int          mode = M_REAL;
  int          lat  = 3;
  int          m_cnt = 0;
  logic        m_done = 1'b0;
  logic        m_stale = 1'b0;
  logic [31:0] m_sum = '0;
  logic [31:0] m_a = '0;
  logic [31:0] m_b = '0;

  always #5 clk = ~clk;

  fpadd_issue #(
    .FIFO_DEPTH (DEPTH),
    .TIMEOUT    (TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_tag      (in_tag),
    .add_start   (add_start),
    .add_a       (add_a),
    .add_b       (add_b),
    .add_done    (add_done),
    .add_sum     (add_sum),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sum     (out_sum),
    .out_tag     (out_tag),
    .out_timeout (out_timeout),
    .busy        (busy)
  );

  // Single-precision add for positive normal operands, truncating.
  function automatic logic [31:0] fadd(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] hi, lo;
    logic [7:0]  e, d;
    logic [24:0] mh, ml, s;
    if (y[30:23] > x[30:23]) begin hi = y; lo = x; end
    else begin hi = x; lo = y; end
    e  = hi[30:23];
    d  = hi[30:23] - lo[30:23];
    mh = {2'b01, hi[22:0]};
    ml = {2'b01, lo[22:0]};
    ml = (d > 8'd24) ? '0 : (ml >> d);
    s  = mh + ml;
    if (s[24]) begin s = s >> 1; e = e + 8'd1; end
    return {1'b0, e, s[22:0]};
  endfunction

  // Adder: done is sticky and cleared on the start edge; stale mode keeps the
  // old done high for one more cycle before the real result arrives.
  always @(posedge clk) begin
    if (add_start) begin
      m_a   <= add_a;
      m_b   <= add_b;
      m_cnt <= lat;
      if (mode == M_STALE) begin
        m_done  <= 1'b1;
        m_sum   <= 32'hDEADBEEF;
        m_stale <= 1'b1;
      end else begin
        m_done <= 1'b0;
      end
    end else if (m_stale) begin
      m_stale <= 1'b0;
      m_done  <= 1'b0;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1 && mode != M_NEVER) begin
        m_done <= 1'b1;
        m_sum  <= (mode == M_STALE) ? 32'h12345678 : fadd(m_a, m_b);
      end
    end
  end

  assign add_done = m_done;
  assign add_sum  = m_sum;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // One clock: records handshakes that happen on this edge, then samples.
  task automatic tick();
    logic acc_in, acc_out, ov_before, empty_sb;
    exp_t got, e;
    acc_in    = in_valid && in_ready;
    acc_out   = out_valid && out_ready;
    ov_before = out_valid;
    got       = '{sum: out_sum, tag: out_tag, to: out_timeout};
    @(posedge clk);
    #1;
    cyc++;
    if (acc_in) begin
      sb.push_back(pend);
      in_valid = 1'b0;
      n_accepted++;
    end
    if (acc_out) begin
      empty_sb = (sb.size() == 0);
      check("sb_underflow", {31'd0, empty_sb}, 32'd0);
      if (!empty_sb) begin
        e = sb.pop_front();
        check("out_tag", {28'd0, got.tag}, {28'd0, e.tag});
        check("out_sum", got.sum, e.sum);
        check("out_timeout", {31'd0, got.to}, {31'd0, e.to});
      end
    end
    if (add_start) start_cyc = cyc;
    if (add_done && !prev_done) rise_cyc = cyc;
    prev_done = add_done;
    if (out_valid && (!ov_before || acc_out)) begin
      last_out_cyc = cyc;
      out_count++;
      if (chk_lat) check("done_to_out", cyc - rise_cyc, 32'd1);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [3:0] t, input exp_t e);
    in_a = a; in_b = b; in_tag = t; in_valid = 1'b1; pend = e;
    for (int i = 0; i < 50 && in_valid; i++) tick();
    if (in_valid) begin
      check("accept_timeout", {31'd0, in_valid}, 32'd0);
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && (sb.size() != 0 || busy || in_valid); i++) tick();
    check("drain_sb_empty", sb.size(), 32'd0);
    check("drain_busy", {31'd0, busy}, 32'd0);
  endtask

  function automatic logic [31:0] opa(input int i);
    return 32'h3F800000 + (i << 20);
  endfunction

  function automatic logic [31:0] opb(input int i);
    return 32'h40000000 + (i << 18);
  endfunction

  initial begin
    int base_acc, base_out, ov_seen;

    // Reset state.
    reset = 1'b1;
    tick(); tick();
    check("in_ready_in_reset", {31'd0, in_ready}, 32'd0);
    check("busy_in_reset", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    tick();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_sum", out_sum, 32'd0);
    check("rst_out_tag", {28'd0, out_tag}, 32'd0);
    check("rst_out_timeout", {31'd0, out_timeout}, 32'd0);
    check("rst_add_start", {31'd0, add_start}, 32'd0);
    check("rst_add_a", add_a, 32'd0);
    check("rst_add_b", add_b, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Single real add: 1.0 + 2.0 = 3.0.
    mode = M_REAL; lat = 3; out_ready = 1'b1;
    drive(32'h3F800000, 32'h40000000, 4'd3, '{sum: 32'h40400000, tag: 4'd3, to: 1'b0});
    drain();

    // Backpressure: result slot held, FIFO fills behind it.
    out_ready = 1'b0;
    base_acc = n_accepted;
    for (int i = 0; i < 5; i++)
      drive(opa(i), opb(i), 4'(i), '{sum: fadd(opa(i), opb(i)), tag: 4'(i), to: 1'b0});
    in_a = opa(5); in_b = opb(5); in_tag = 4'd5; in_valid = 1'b1;
    pend = '{sum: fadd(opa(5), opb(5)), tag: 4'd5, to: 1'b0};
    for (int i = 0; i < 20; i++) tick();
    check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    check("bp_accepted", n_accepted - base_acc, 32'd5);
    check("bp_out_tag0", {28'd0, out_tag}, 32'd0);
    out_ready = 1'b1;
    drain();
    check("bp_accepted_all", n_accepted - base_acc, 32'd6);

    // Timeout: adder never completes.
    mode = M_NEVER;
    drive(opa(7), opb(7), 4'd7, '{sum: 32'd0, tag: 4'd7, to: 1'b1});
    drain();
    check("timeout_latency", last_out_cyc - start_cyc, TO + 2);

    // Stale done from the previous add must be ignored.
    mode = M_STALE; lat = 4;
    drive(opa(9), opb(9), 4'd9, '{sum: 32'h12345678, tag: 4'd9, to: 1'b0});
    drain();

    // Reset while waiting with two pairs queued.
    mode = M_REAL; lat = 12;
    for (int i = 1; i < 4; i++)
      drive(opa(i), opb(i), 4'(i), '{sum: fadd(opa(i), opb(i)), tag: 4'(i), to: 1'b0});
    for (int i = 0; i < 4; i++) tick();
    check("pre_reset_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("mid_reset_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    sb.delete();
    check("wr_out_valid", {31'd0, out_valid}, 32'd0);
    check("wr_out_sum", out_sum, 32'd0);
    check("wr_add_a", add_a, 32'd0);
    check("wr_add_start", {31'd0, add_start}, 32'd0);
    check("wr_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    ov_seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid) ov_seen++;
    end
    check("late_done_seen", {31'd0, add_done}, 32'd1);
    check("late_done_dropped", ov_seen, 32'd0);
    check("post_reset_busy", {31'd0, busy}, 32'd0);

    // Drain/issue overlap with the consumer always ready.
    lat = 2; out_ready = 1'b1; chk_lat = 1'b1;
    base_out = out_count;
    for (int i = 10; i < 14; i++)
      drive(opa(i), opb(i), 4'(i), '{sum: fadd(opa(i), opb(i)), tag: 4'(i), to: 1'b0});
    drain();
    chk_lat = 1'b0;
    check("overlap_count", out_count - base_out, 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
